// File: rtl/id_control_seq_pkg.sv
// Shared types and encodings for the ID-stage sequential control unit:
// control-word layout, field codes, opcodes/functs and FSM states.
package id_ctrl_pkg;

  localparam int unsigned NB_CTRL      = 19;
  localparam int unsigned NB_OP        = 6;
  localparam int unsigned NB_FUNCT     = 6;
  localparam int unsigned NB_JMP       = 2;
  localparam int unsigned NB_REG_DST   = 2;
  localparam int unsigned NB_SRC_B     = 2;
  localparam int unsigned NB_ALU       = 3;
  localparam int unsigned NB_MEM_RD    = 3;
  localparam int unsigned NB_MEM_WR    = 2;
  localparam int unsigned NB_MULDIV_OP = 2;

  // Control word, MSB first: b18 next_pc_src ... b0 mem_to_reg
  typedef struct packed {
    logic                  next_pc_src;
    logic [NB_JMP-1:0]     jmp;
    logic [NB_REG_DST-1:0] reg_dst;
    logic                  src_a;
    logic [NB_SRC_B-1:0]   src_b;
    logic [NB_ALU-1:0]     alu_op;
    logic [NB_MEM_RD-1:0]  mem_rd;
    logic [NB_MEM_WR-1:0]  mem_wr;
    logic                  mem_write;
    logic                  wb;
    logic                  mem_to_reg;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  localparam logic [NB_JMP-1:0]     CODE_JMP_NOT     = 2'b00;
  localparam logic [NB_JMP-1:0]     CODE_JMP_DIR     = 2'b01;
  localparam logic [NB_JMP-1:0]     CODE_JMP_REG     = 2'b10;
  localparam logic [NB_JMP-1:0]     CODE_JMP_BRANCH  = 2'b11;
  localparam logic [NB_REG_DST-1:0] CODE_DST_RT      = 2'b00;
  localparam logic [NB_REG_DST-1:0] CODE_DST_RD      = 2'b01;
  localparam logic [NB_REG_DST-1:0] CODE_DST_RA      = 2'b10;
  localparam logic                  CODE_SRC_A_RS    = 1'b0;
  localparam logic                  CODE_SRC_A_SHAMT = 1'b1;
  localparam logic [NB_SRC_B-1:0]   CODE_SRC_B_RT    = 2'b00;
  localparam logic [NB_SRC_B-1:0]   CODE_SRC_B_SIMM  = 2'b01;
  localparam logic [NB_SRC_B-1:0]   CODE_SRC_B_ZIMM  = 2'b10;
  localparam logic [NB_ALU-1:0]     CODE_ALU_R       = 3'b000;
  localparam logic [NB_ALU-1:0]     CODE_ALU_ADD     = 3'b001;
  localparam logic [NB_ALU-1:0]     CODE_ALU_SUB     = 3'b010;
  localparam logic [NB_ALU-1:0]     CODE_ALU_AND     = 3'b011;
  localparam logic [NB_ALU-1:0]     CODE_ALU_OR      = 3'b100;
  localparam logic [NB_ALU-1:0]     CODE_ALU_XOR     = 3'b101;
  localparam logic [NB_ALU-1:0]     CODE_ALU_LUI     = 3'b110;
  localparam logic [NB_ALU-1:0]     CODE_ALU_SLT     = 3'b111;
  localparam logic [NB_MEM_RD-1:0]  CODE_RD_WORD     = 3'b000;
  localparam logic [NB_MEM_RD-1:0]  CODE_RD_HALF     = 3'b001;
  localparam logic [NB_MEM_RD-1:0]  CODE_RD_BYTE     = 3'b010;
  localparam logic [NB_MEM_RD-1:0]  CODE_RD_HALFU    = 3'b011;
  localparam logic [NB_MEM_RD-1:0]  CODE_RD_BYTEU    = 3'b100;
  localparam logic [NB_MEM_WR-1:0]  CODE_WR_WORD     = 2'b00;
  localparam logic [NB_MEM_WR-1:0]  CODE_WR_HALF     = 2'b01;
  localparam logic [NB_MEM_WR-1:0]  CODE_WR_BYTE     = 2'b10;

  localparam logic [NB_OP-1:0] OP_RTYPE = 6'b000000;
  localparam logic [NB_OP-1:0] OP_J     = 6'b000010;
  localparam logic [NB_OP-1:0] OP_JAL   = 6'b000011;
  localparam logic [NB_OP-1:0] OP_BEQ   = 6'b000100;
  localparam logic [NB_OP-1:0] OP_BNE   = 6'b000101;
  localparam logic [NB_OP-1:0] OP_ADDI  = 6'b001000;
  localparam logic [NB_OP-1:0] OP_ADDIU = 6'b001001;
  localparam logic [NB_OP-1:0] OP_SLTI  = 6'b001010;
  localparam logic [NB_OP-1:0] OP_ANDI  = 6'b001100;
  localparam logic [NB_OP-1:0] OP_ORI   = 6'b001101;
  localparam logic [NB_OP-1:0] OP_XORI  = 6'b001110;
  localparam logic [NB_OP-1:0] OP_LUI   = 6'b001111;
  localparam logic [NB_OP-1:0] OP_LB    = 6'b100000;
  localparam logic [NB_OP-1:0] OP_LH    = 6'b100001;
  localparam logic [NB_OP-1:0] OP_LW    = 6'b100011;
  localparam logic [NB_OP-1:0] OP_LBU   = 6'b100100;
  localparam logic [NB_OP-1:0] OP_LHU   = 6'b100101;
  localparam logic [NB_OP-1:0] OP_SB    = 6'b101000;
  localparam logic [NB_OP-1:0] OP_SH    = 6'b101001;
  localparam logic [NB_OP-1:0] OP_SW    = 6'b101011;
  localparam logic [NB_OP-1:0] OP_HALT  = 6'b111111;

  localparam logic [NB_FUNCT-1:0] F_SLL   = 6'b000000;
  localparam logic [NB_FUNCT-1:0] F_SRL   = 6'b000010;
  localparam logic [NB_FUNCT-1:0] F_SRA   = 6'b000011;
  localparam logic [NB_FUNCT-1:0] F_JR    = 6'b001000;
  localparam logic [NB_FUNCT-1:0] F_JALR  = 6'b001001;
  localparam logic [NB_FUNCT-1:0] F_MFHI  = 6'b010000;
  localparam logic [NB_FUNCT-1:0] F_MTHI  = 6'b010001;
  localparam logic [NB_FUNCT-1:0] F_MFLO  = 6'b010010;
  localparam logic [NB_FUNCT-1:0] F_MTLO  = 6'b010011;
  localparam logic [NB_FUNCT-1:0] F_MULT  = 6'b011000;
  localparam logic [NB_FUNCT-1:0] F_MULTU = 6'b011001;
  localparam logic [NB_FUNCT-1:0] F_DIV   = 6'b011010;
  localparam logic [NB_FUNCT-1:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, HALTED = 2'd2} state_t;

endpackage

// File: rtl/id_control_seq_if.sv
// IF/ID-side pipeline signals into, and ID/EX controls out of, the ID control unit.
interface id_control_seq_if;
  import id_ctrl_pkg::*;

  logic                    i_enable;
  logic                    i_valid;
  logic [NB_OP-1:0]        i_op;
  logic [NB_FUNCT-1:0]     i_funct;
  logic                    i_bus_a_is_zero;
  logic                    i_stall;
  logic                    i_flush;
  logic                    i_resume;
  logic                    o_next_pc_src;
  logic [NB_JMP-1:0]       o_jmp_ctrl;
  logic [NB_CTRL-1:0]      o_ctrl_regs;
  logic                    o_valid;
  logic                    o_stall_req;
  logic                    o_muldiv_start;
  logic [NB_MULDIV_OP-1:0] o_muldiv_op;
  logic                    o_busy;
  logic                    o_halt;

  modport master (
    output i_enable, i_valid, i_op, i_funct, i_bus_a_is_zero, i_stall, i_flush, i_resume,
    input  o_next_pc_src, o_jmp_ctrl, o_ctrl_regs, o_valid, o_stall_req,
           o_muldiv_start, o_muldiv_op, o_busy, o_halt
  );

  modport slave (
    input  i_enable, i_valid, i_op, i_funct, i_bus_a_is_zero, i_stall, i_flush, i_resume,
    output o_next_pc_src, o_jmp_ctrl, o_ctrl_regs, o_valid, o_stall_req,
           o_muldiv_start, o_muldiv_op, o_busy, o_halt
  );
endinterface

// File: rtl/id_control_seq_decode.sv
// Combinational main decoder: op/funct/branch compare -> control word plus
// classification flags used by the interlock FSM.
module id_ctrl_decode
  import id_ctrl_pkg::*;
(
  input  logic [NB_OP-1:0]    op,
  input  logic [NB_FUNCT-1:0] funct,
  input  logic                bus_a_is_zero,
  output ctrl_t               ctrl,
  output logic                is_muldiv,
  output logic                is_hilo,
  output logic                is_halt
);

  always_comb begin
    ctrl = CTRL_NOP;
    case (op)
      OP_RTYPE: begin
        ctrl.reg_dst = CODE_DST_RD;
        ctrl.alu_op  = CODE_ALU_R;
        ctrl.wb      = 1'b1;
        case (funct)
          F_SLL, F_SRL, F_SRA: ctrl.src_a = CODE_SRC_A_SHAMT;
          F_JR: begin
            ctrl             = CTRL_NOP;
            ctrl.next_pc_src = 1'b1;
            ctrl.jmp         = CODE_JMP_REG;
          end
          F_JALR: begin
            ctrl.next_pc_src = 1'b1;
            ctrl.jmp         = CODE_JMP_REG;
          end
          F_MTHI, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU: ctrl.wb = 1'b0;
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl.wb    = 1'b1;
        ctrl.src_b = CODE_SRC_B_ZIMM;
        case (op)
          OP_SLTI: begin ctrl.src_b = CODE_SRC_B_SIMM; ctrl.alu_op = CODE_ALU_SLT; end
          OP_ANDI: ctrl.alu_op = CODE_ALU_AND;
          OP_ORI:  ctrl.alu_op = CODE_ALU_OR;
          OP_XORI: ctrl.alu_op = CODE_ALU_XOR;
          OP_LUI:  ctrl.alu_op = CODE_ALU_LUI;
          default: begin ctrl.src_b = CODE_SRC_B_SIMM; ctrl.alu_op = CODE_ALU_ADD; end
        endcase
      end
      OP_BEQ, OP_BNE: begin
        ctrl.alu_op = CODE_ALU_SUB;
        // Taken branches redirect the PC; not-taken ones fall through
        if ((op == OP_BEQ) == bus_a_is_zero) begin
          ctrl.next_pc_src = 1'b1;
          ctrl.jmp         = CODE_JMP_BRANCH;
        end
      end
      OP_J, OP_JAL: begin
        ctrl.next_pc_src = 1'b1;
        ctrl.jmp         = CODE_JMP_DIR;
        if (op == OP_JAL) begin
          ctrl.reg_dst = CODE_DST_RA;
          ctrl.wb      = 1'b1;
        end
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        ctrl.src_b      = CODE_SRC_B_SIMM;
        ctrl.alu_op     = CODE_ALU_ADD;
        ctrl.wb         = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        case (op)
          OP_LB:   ctrl.mem_rd = CODE_RD_BYTE;
          OP_LH:   ctrl.mem_rd = CODE_RD_HALF;
          OP_LBU:  ctrl.mem_rd = CODE_RD_BYTEU;
          OP_LHU:  ctrl.mem_rd = CODE_RD_HALFU;
          default: ctrl.mem_rd = CODE_RD_WORD;
        endcase
      end
      OP_SB, OP_SH, OP_SW: begin
        ctrl.src_b     = CODE_SRC_B_SIMM;
        ctrl.alu_op    = CODE_ALU_ADD;
        ctrl.mem_write = 1'b1;
        case (op)
          OP_SB:   ctrl.mem_wr = CODE_WR_BYTE;
          OP_SH:   ctrl.mem_wr = CODE_WR_HALF;
          default: ctrl.mem_wr = CODE_WR_WORD;
        endcase
      end
      default: ctrl = CTRL_NOP;
    endcase
  end

  assign is_muldiv = (op == OP_RTYPE) &&
                     (funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
  assign is_hilo   = (op == OP_RTYPE) &&
                     (funct inside {F_MFHI, F_MFLO, F_MTHI, F_MTLO});
  assign is_halt   = (op == OP_HALT);

endmodule

// File: rtl/id_control_seq.sv
// ID-stage control sequencer: decode, ID/EX control register with bubble
// insertion, MULT/DIV busy FSM with HI/LO interlock, and HALT handling.
module id_control_seq
  import id_ctrl_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  id_control_seq_if.slave  bus
);

  localparam int unsigned        NB_CNT   = $clog2(MULDIV_LAT + 1);
  localparam logic [NB_CNT-1:0] CNT_LOAD = NB_CNT'(MULDIV_LAT - 1);
  localparam logic [NB_CNT-1:0] CNT_ONE  = NB_CNT'(1);

  state_t                  state_q, state_nx;
  logic [NB_CNT-1:0]       cnt_q, cnt_nx;
  ctrl_t                   ctrl_q, ctrl_nx;
  logic                    valid_q, valid_nx;
  logic                    start_q, start_nx;
  logic [NB_MULDIV_OP-1:0] mop_q, mop_nx;
  logic                    busy_q, busy_nx;
  logic                    halt_q, halt_nx;

  ctrl_t dec_ctrl;
  logic  dec_muldiv, dec_hilo, dec_halt;
  logic  stall_req_c, live_c, accept_c;

  id_ctrl_decode u_decode (
    .op            (bus.i_op),
    .funct         (bus.i_funct),
    .bus_a_is_zero (bus.i_bus_a_is_zero),
    .ctrl          (dec_ctrl),
    .is_muldiv     (dec_muldiv),
    .is_hilo       (dec_hilo),
    .is_halt       (dec_halt)
  );

  // HI/LO users, new muldivs and HALT must wait for the unit to drain
  assign stall_req_c = (state_q == BUSY) && bus.i_valid &&
                       (dec_muldiv || dec_hilo || dec_halt);
  assign live_c      = bus.i_valid && bus.i_enable && !bus.i_flush &&
                       !stall_req_c && (state_q != HALTED);
  assign accept_c    = live_c && !bus.i_stall;

  assign bus.o_next_pc_src = live_c && dec_ctrl.next_pc_src;
  assign bus.o_jmp_ctrl    = live_c ? dec_ctrl.jmp : CODE_JMP_NOT;
  assign bus.o_stall_req   = stall_req_c;

  // Next-state and ID/EX register contents; i_enable=0 holds everything
  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    ctrl_nx  = ctrl_q;
    valid_nx = valid_q;
    start_nx = start_q;
    mop_nx   = mop_q;
    busy_nx  = busy_q;
    halt_nx  = halt_q;
    if (bus.i_enable) begin
      start_nx = 1'b0;
      if ((state_q == HALTED) || bus.i_flush || bus.i_stall || stall_req_c) begin
        ctrl_nx  = CTRL_NOP;
        valid_nx = 1'b0;
      end else begin
        ctrl_nx  = dec_ctrl;
        valid_nx = bus.i_valid;
      end
      case (state_q)
        IDLE: begin
          if (accept_c && dec_muldiv) begin
            state_nx = BUSY;
            start_nx = 1'b1;
            mop_nx   = bus.i_funct[NB_MULDIV_OP-1:0];
            cnt_nx   = CNT_LOAD;
            busy_nx  = 1'b1;
          end else if (accept_c && dec_halt) begin
            state_nx = HALTED;
            halt_nx  = 1'b1;
          end
        end
        BUSY: begin
          cnt_nx = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_nx = IDLE;
            busy_nx  = 1'b0;
          end
        end
        HALTED: begin
          if (bus.i_resume) begin
            state_nx = IDLE;
            halt_nx  = 1'b0;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ctrl_q  <= CTRL_NOP;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      mop_q   <= '0;
      busy_q  <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
      ctrl_q  <= ctrl_nx;
      valid_q <= valid_nx;
      start_q <= start_nx;
      mop_q   <= mop_nx;
      busy_q  <= busy_nx;
      halt_q  <= halt_nx;
    end
  end

  assign bus.o_ctrl_regs    = ctrl_q;
  assign bus.o_valid        = valid_q;
  assign bus.o_muldiv_start = start_q;
  assign bus.o_muldiv_op    = mop_q;
  assign bus.o_busy         = busy_q;
  assign bus.o_halt         = halt_q;

endmodule
